// File: rtl/io_port_controller.sv
// Memory-mapped output channel registers plus a button-qualified input capture
// FSM that holds the core in stall while an IN instruction waits for the user.
module io_port_controller #(
    parameter int          DATA_W    = 32,
    parameter int          IN_W      = 16,
    parameter int          N_OUT     = 4,
    parameter logic [31:0] BASE_ADDR = 32'd1000,
    parameter bit          SIGN_EXT  = 1'b1,
    parameter int          TIMEOUT   = 0
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic [31:0]             adress,
    input  logic [DATA_W-1:0]       writedata,
    input  logic                    MemWrite,
    input  logic                    in_req,
    input  logic                    btn_pulse,
    input  logic [IN_W-1:0]         switches,
    output logic                    stall,
    output logic [DATA_W-1:0]       in_data,
    output logic                    in_valid,
    output logic                    in_timeout,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_strobe,
    output logic [15:0]             out_count
);
    // state    | meaning
    // IDLE     | no IN pending; button pulses are ignored
    // WAIT_BTN | IN pending, core stalled until button or timeout
    // DONE     | in_data valid for exactly one cycle, stall released
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BTN = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              timeout_hit;
    logic [DATA_W-1:0] sw_ext;
    logic [31:0]       wr_offset;
    logic              wr_hit;

    assign timeout_hit = (TIMEOUT > 0) && (state == WAIT_BTN) && (wait_cnt == CNT_LAST);

    always_comb begin
        sw_ext = '0;
        sw_ext[IN_W-1:0] = switches;
        for (int i = IN_W; i < DATA_W; i++) begin
            sw_ext[i] = SIGN_EXT & switches[IN_W-1];
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Losing in_req wins over a same-cycle button: the instruction is gone.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (in_req) state_nxt = WAIT_BTN;
            WAIT_BTN: begin
                if (!in_req) begin
                    state_nxt = IDLE;
                end else if (btn_pulse || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall    = in_req && (state != DONE) && !rst;
        in_valid = (state == DONE);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state != WAIT_BTN) begin
            wait_cnt <= '0;
        end else if ((TIMEOUT > 0) && !timeout_hit) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            in_data    <= '0;
            in_timeout <= 1'b0;
        end else if (state == WAIT_BTN && in_req) begin
            if (btn_pulse) begin
                in_data    <= sw_ext;
                in_timeout <= 1'b0;
            end else if (timeout_hit) begin
                in_data    <= '0;
                in_timeout <= 1'b1;
            end
        end
    end

    // Unsigned offset: addresses below BASE_ADDR wrap to huge values and miss.
    assign wr_offset = adress - BASE_ADDR;
    assign wr_hit    = MemWrite && (wr_offset < 32'(N_OUT));

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            out_strobe <= '0;
            out_count  <= '0;
        end else begin
            out_strobe <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                if (wr_hit && wr_offset == 32'(i)) begin
                    out_data[i*DATA_W +: DATA_W] <= writedata;
                    out_strobe[i]                <= 1'b1;
                end
            end
            if (wr_hit && out_count != 16'hFFFF) begin
                out_count <= out_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_io_port_controller.sv
// Bench for io_port_controller: three instances (sign-extend, zero-extend,
// timeout=10) share stimulus and are compared against a behavioural model.
module tb_io_port_controller;
    localparam int          DATA_W = 32;
    localparam int          IN_W   = 16;
    localparam int          N_OUT  = 4;
    localparam logic [31:0] BASE   = 32'd1000;
    localparam int          TMO    = 10;

    logic                    clock = 1'b0;
    logic                    rst;
    logic                    MemWrite;
    logic                    in_req;
    logic                    btn_pulse;
    logic [31:0]             adress;
    logic [31:0]             writedata;
    logic [IN_W-1:0]         switches;

    logic                    stall_s, stall_z, stall_t;
    logic [DATA_W-1:0]       in_data_s, in_data_z, in_data_t;
    logic                    in_valid_s, in_valid_z, in_valid_t;
    logic                    in_timeout_s, in_timeout_z, in_timeout_t;
    logic [N_OUT*DATA_W-1:0] out_data_s, out_data_z, out_data_t;
    logic [N_OUT-1:0]        out_strobe_s, out_strobe_z, out_strobe_t;
    logic [15:0]             out_count_s, out_count_z, out_count_t;

    io_port_controller #(.SIGN_EXT(1'b1)) dut_s (
        .clock(clock), .rst(rst), .adress(adress), .writedata(writedata),
        .MemWrite(MemWrite), .in_req(in_req), .btn_pulse(btn_pulse), .switches(switches),
        .stall(stall_s), .in_data(in_data_s), .in_valid(in_valid_s), .in_timeout(in_timeout_s),
        .out_data(out_data_s), .out_strobe(out_strobe_s), .out_count(out_count_s));

    io_port_controller #(.SIGN_EXT(1'b0)) dut_z (
        .clock(clock), .rst(rst), .adress(adress), .writedata(writedata),
        .MemWrite(MemWrite), .in_req(in_req), .btn_pulse(btn_pulse), .switches(switches),
        .stall(stall_z), .in_data(in_data_z), .in_valid(in_valid_z), .in_timeout(in_timeout_z),
        .out_data(out_data_z), .out_strobe(out_strobe_z), .out_count(out_count_z));

    io_port_controller #(.TIMEOUT(TMO)) dut_t (
        .clock(clock), .rst(rst), .adress(adress), .writedata(writedata),
        .MemWrite(MemWrite), .in_req(in_req), .btn_pulse(btn_pulse), .switches(switches),
        .stall(stall_t), .in_data(in_data_t), .in_valid(in_valid_t), .in_timeout(in_timeout_t),
        .out_data(out_data_t), .out_strobe(out_strobe_t), .out_count(out_count_t));

    always #5 clock = ~clock;

    int               total = 0;
    int               bad   = 0;
    logic [31:0]      m_ch [N_OUT];
    logic [N_OUT-1:0] m_strobe;
    int               m_count;
    logic [31:0]      m_last_s;

    function automatic logic [31:0] extend(input logic [15:0] sw, input bit sgn);
        int unsigned v;
        v = 32'(sw);
        if (sgn && sw >= 16'd32768) v = v + 32'hFFFF0000;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_OUT; i++) m_ch[i] = '0;
        m_strobe = '0;
        m_count  = 0;
        m_last_s = '0;
    endtask

    // Drives one bus cycle and predicts its effect from the address map.
    task automatic drive_write(input logic [31:0] addr, input logic [31:0] data, input bit we);
        longint a;
        int     idx;
        a         = longint'(addr);
        MemWrite  = we;
        adress    = addr;
        writedata = data;
        m_strobe  = '0;
        if (we && a >= longint'(BASE) && a < longint'(BASE) + N_OUT) begin
            idx           = int'(a - longint'(BASE));
            m_ch[idx]     = data;
            m_strobe[idx] = 1'b1;
            if (m_count < 65535) m_count++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_req = 1'b1; MemWrite = 1'b0; btn_pulse = 1'b0;
        adress = '0; writedata = '0; switches = 16'hFFFF;
        model_reset();
        repeat (2) @(negedge clock);
        total++; if (stall_s !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall_s); end
        total++; if (in_valid_s !== 1'b0) begin bad++; $display("FAIL rst_in_valid: got %b want 0", in_valid_s); end
        total++; if (in_data_s !== '0) begin bad++; $display("FAIL rst_in_data: got %h want 0", in_data_s); end
        total++; if (in_timeout_t !== 1'b0) begin bad++; $display("FAIL rst_in_timeout: got %b want 0", in_timeout_t); end
        total++; if (out_data_s !== '0) begin bad++; $display("FAIL rst_out_data: got %h want 0", out_data_s); end
        total++; if (out_strobe_s !== '0) begin bad++; $display("FAIL rst_out_strobe: got %b want 0", out_strobe_s); end
        total++; if (out_count_s !== '0) begin bad++; $display("FAIL rst_out_count: got %0d want 0", out_count_s); end
        in_req = 1'b0;
        rst    = 1'b0;
        @(negedge clock);
    endtask

    // One IN instruction from IDLE; the button arrives in wait cycle nwait.
    task automatic run_capture(input int nwait, input logic [15:0] sw, input bit idle_btn, input bit hold_req);
        int stall_cnt;
        stall_cnt = 0;
        in_req    = 1'b1;
        switches  = sw;
        btn_pulse = idle_btn;
        #1;
        if (stall_s) stall_cnt++;
        for (int k = 1; k <= nwait; k++) begin
            @(negedge clock);
            btn_pulse = (k == nwait);
            total++;
            if (in_valid_s !== 1'b0) begin bad++; $display("FAIL cap_early_valid: wait=%0d got %b want 0", k, in_valid_s); end
            if (stall_s) stall_cnt++;
        end
        @(negedge clock);
        btn_pulse = 1'b0;
        total++; if (in_valid_s !== 1'b1) begin bad++; $display("FAIL cap_valid: got %b want 1", in_valid_s); end
        total++; if (stall_s !== 1'b0) begin bad++; $display("FAIL cap_stall_done: got %b want 0", stall_s); end
        total++; if (stall_cnt != nwait + 1) begin bad++; $display("FAIL cap_stall_len: got %0d want %0d", stall_cnt, nwait + 1); end
        total++; if (in_data_s !== extend(sw, 1'b1)) begin bad++; $display("FAIL cap_data_sext: got %h want %h", in_data_s, extend(sw, 1'b1)); end
        total++; if (in_data_z !== extend(sw, 1'b0)) begin bad++; $display("FAIL cap_data_zext: got %h want %h", in_data_z, extend(sw, 1'b0)); end
        total++; if (in_valid_t !== 1'b1 || in_data_t !== extend(sw, 1'b1)) begin
            bad++; $display("FAIL cap_data_tmo: got valid=%b data=%h want valid=1 data=%h", in_valid_t, in_data_t, extend(sw, 1'b1));
        end
        total++; if (in_timeout_t !== 1'b0) begin bad++; $display("FAIL cap_timeout_flag: got %b want 0", in_timeout_t); end
        m_last_s = extend(sw, 1'b1);
        if (!hold_req) in_req = 1'b0;
        @(negedge clock);
        total++; if (in_valid_s !== 1'b0) begin bad++; $display("FAIL cap_valid_len: got %b want 0", in_valid_s); end
    endtask

    task automatic test_capture_directed();
        run_capture(5, 16'h8001, 1'b0, 1'b0);
        total++; if (m_last_s !== 32'hFFFF8001 || in_data_z !== 32'h00008001) begin
            bad++; $display("FAIL cap_8001: got sext=%h zext=%h want FFFF8001 00008001", in_data_s, in_data_z);
        end
    endtask

    task automatic test_timeout();
        in_req    = 1'b1;
        switches  = 16'($urandom);
        btn_pulse = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clock);
            total++; if (in_valid_t !== 1'b0) begin bad++; $display("FAIL tmo_early: wait=%0d got %b want 0", k, in_valid_t); end
        end
        @(negedge clock);
        total++; if (in_valid_t !== 1'b1) begin bad++; $display("FAIL tmo_valid: got %b want 1", in_valid_t); end
        total++; if (in_data_t !== '0) begin bad++; $display("FAIL tmo_data: got %h want 0", in_data_t); end
        total++; if (in_timeout_t !== 1'b1) begin bad++; $display("FAIL tmo_flag: got %b want 1", in_timeout_t); end
        total++; if (stall_t !== 1'b0) begin bad++; $display("FAIL tmo_stall: got %b want 0", stall_t); end
        total++; if (stall_s !== 1'b1 || in_valid_s !== 1'b0) begin
            bad++; $display("FAIL tmo_disabled: got stall=%b valid=%b want 1 0", stall_s, in_valid_s);
        end
        @(negedge clock);
        total++; if (stall_t !== 1'b1) begin bad++; $display("FAIL tmo_restall: got %b want 1", stall_t); end
        in_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        total++; if (stall_s !== 1'b0 || in_valid_s !== 1'b0) begin
            bad++; $display("FAIL abort_idle: got stall=%b valid=%b want 0 0", stall_s, in_valid_s);
        end
        total++; if (in_data_s !== m_last_s) begin bad++; $display("FAIL abort_data: got %h want %h", in_data_s, m_last_s); end
        total++; if (in_timeout_t !== 1'b1) begin bad++; $display("FAIL tmo_flag_hold: got %b want 1", in_timeout_t); end
    endtask

    task automatic test_button_at_limit();
        run_capture(TMO, 16'($urandom), 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_capture($urandom_range(1, 6), 16'($urandom), 1'b0, 1'b1);
        run_capture($urandom_range(2, 6), 16'($urandom), 1'b1, 1'b0);
    endtask

    task automatic test_random_capture();
        for (int n = 0; n < 6; n++) begin
            run_capture($urandom_range(1, TMO), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic test_writes();
        logic [31:0] t_addr [9];
        logic [31:0] t_data [9];
        bit          t_we   [9];
        t_addr = '{BASE + 2, BASE + 2, BASE + 4, BASE - 1, BASE + 3, BASE + 3, BASE, 32'd0, 32'hFFFF_FFFF};
        t_data = '{32'd1234, 32'd99, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1111_0000, 32'h2222_0000, 32'h7, 32'h8, 32'h9};
        t_we   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int n = 0; n < 9; n++) begin
            drive_write(t_addr[n], t_data[n], t_we[n]);
            @(negedge clock);
            for (int i = 0; i < N_OUT; i++) begin
                total++; if (out_data_s[i*DATA_W +: DATA_W] !== m_ch[i]) begin
                    bad++; $display("FAIL wr_dir_ch%0d: step=%0d got %h want %h", i, n, out_data_s[i*DATA_W +: DATA_W], m_ch[i]);
                end
            end
            total++; if (out_strobe_s !== m_strobe) begin bad++; $display("FAIL wr_dir_strobe: step=%0d got %b want %b", n, out_strobe_s, m_strobe); end
            total++; if (out_count_s !== 16'(m_count)) begin bad++; $display("FAIL wr_dir_count: step=%0d got %0d want %0d", n, out_count_s, m_count); end
        end
        total++; if (out_data_s[2*DATA_W +: DATA_W] !== 32'd1234) begin
            bad++; $display("FAIL wr_ch2_1234: got %0d want 1234", out_data_s[2*DATA_W +: DATA_W]);
        end
        drive_write(32'd0, 32'd0, 1'b0);
        @(negedge clock);
    endtask

    task automatic test_random_writes();
        for (int n = 0; n < 300; n++) begin
            drive_write(BASE - 3 + 32'($urandom_range(0, N_OUT + 5)), $urandom, 1'($urandom_range(0, 1)));
            @(negedge clock);
            for (int i = 0; i < N_OUT; i++) begin
                total++; if (out_data_s[i*DATA_W +: DATA_W] !== m_ch[i]) begin
                    bad++; $display("FAIL wr_rnd_ch%0d: iter=%0d got %h want %h", i, n, out_data_s[i*DATA_W +: DATA_W], m_ch[i]);
                end
            end
            total++; if (out_strobe_s !== m_strobe) begin bad++; $display("FAIL wr_rnd_strobe: iter=%0d got %b want %b", n, out_strobe_s, m_strobe); end
            total++; if (out_count_s !== 16'(m_count)) begin bad++; $display("FAIL wr_rnd_count: iter=%0d got %0d want %0d", n, out_count_s, m_count); end
        end
        drive_write(32'd0, 32'd0, 1'b0);
        @(negedge clock);
    endtask

    task automatic test_concurrent();
        logic [15:0] sw;
        sw        = 16'($urandom);
        in_req    = 1'b1;
        switches  = sw;
        btn_pulse = 1'b0;
        repeat (3) @(negedge clock);
        btn_pulse = 1'b1;
        drive_write(BASE + 1, $urandom, 1'b1);
        @(negedge clock);
        btn_pulse = 1'b0;
        total++; if (in_valid_s !== 1'b1 || in_data_s !== extend(sw, 1'b1)) begin
            bad++; $display("FAIL conc_capture: got valid=%b data=%h want 1 %h", in_valid_s, in_data_s, extend(sw, 1'b1));
        end
        total++; if (out_strobe_s !== m_strobe) begin bad++; $display("FAIL conc_strobe: got %b want %b", out_strobe_s, m_strobe); end
        total++; if (out_data_s[DATA_W +: DATA_W] !== m_ch[1]) begin
            bad++; $display("FAIL conc_ch1: got %h want %h", out_data_s[DATA_W +: DATA_W], m_ch[1]);
        end
        total++; if (out_count_s !== 16'(m_count)) begin bad++; $display("FAIL conc_count: got %0d want %0d", out_count_s, m_count); end
        m_last_s = extend(sw, 1'b1);
        in_req   = 1'b0;
        drive_write(32'd0, 32'd0, 1'b0);
        @(negedge clock);
    endtask

    task automatic test_reset_mid_wait();
        drive_write(BASE + 1, 32'hA5A5_0001, 1'b1);
        @(negedge clock);
        drive_write(32'd0, 32'd0, 1'b0);
        in_req   = 1'b1;
        switches = 16'($urandom);
        repeat (4) @(negedge clock);
        total++; if (stall_s !== 1'b1) begin bad++; $display("FAIL rmw_pre_stall: got %b want 1", stall_s); end
        rst = 1'b1;
        model_reset();
        #1;
        total++; if (stall_s !== 1'b0 || stall_z !== 1'b0 || stall_t !== 1'b0) begin
            bad++; $display("FAIL rmw_stall: got %b%b%b want 000", stall_s, stall_z, stall_t);
        end
        total++; if (in_data_s !== '0 || in_valid_s !== 1'b0 || in_timeout_t !== 1'b0) begin
            bad++; $display("FAIL rmw_in: got data=%h valid=%b tmo=%b want 0 0 0", in_data_s, in_valid_s, in_timeout_t);
        end
        total++; if (out_data_s !== '0 || out_strobe_s !== '0 || out_count_s !== '0) begin
            bad++; $display("FAIL rmw_out: got data=%h strobe=%b count=%0d want 0", out_data_s, out_strobe_s, out_count_s);
        end
        @(negedge clock);
        rst = 1'b0;
        #1;
        total++; if (stall_s !== 1'b1 || in_valid_s !== 1'b0) begin
            bad++; $display("FAIL rmw_restart: got stall=%b valid=%b want 1 0", stall_s, in_valid_s);
        end
        run_capture(3, 16'($urandom), 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 70000; n++) begin
            drive_write(BASE + 32'($urandom_range(0, N_OUT - 1)), $urandom, 1'b1);
            @(negedge clock);
        end
        total++; if (out_count_s !== 16'(m_count) || out_count_s !== 16'hFFFF) begin
            bad++; $display("FAIL sat_count: got %h want %h", out_count_s, 16'(m_count));
        end
        total++; if (out_count_z !== 16'hFFFF) begin bad++; $display("FAIL sat_count_z: got %h want FFFF", out_count_z); end
        total++; if (out_strobe_s !== m_strobe) begin bad++; $display("FAIL sat_strobe: got %b want %b", out_strobe_s, m_strobe); end
        for (int i = 0; i < N_OUT; i++) begin
            total++; if (out_data_s[i*DATA_W +: DATA_W] !== m_ch[i]) begin
                bad++; $display("FAIL sat_ch%0d: got %h want %h", i, out_data_s[i*DATA_W +: DATA_W], m_ch[i]);
            end
        end
        drive_write(32'd0, 32'd0, 1'b0);
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_capture_directed();
        test_timeout();
        test_button_at_limit();
        test_back_to_back();
        test_random_capture();
        test_writes();
        test_random_writes();
        test_concurrent();
        test_reset_mid_wait();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/io_port_controller.md
IO_PORT_CONTROLLER -- requirements
Module: io_port_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and output channel width.
REQ-002 SHALL have parameter IN_W, default 16, switch input width (IN_W <= DATA_W).
REQ-003 SHALL have parameter N_OUT, default 4, number of output channels (1..16).
REQ-004 SHALL have parameter BASE_ADDR, default 32'd1000, word address of output channel 0.
REQ-005 SHALL have parameter SIGN_EXT, default 1; 1 sign-extends switch input, 0 zero-extends it.
REQ-006 SHALL have parameter TIMEOUT, default 0, input wait limit in cycles; 0 disables the timeout.
REQ-007 SHALL have one clock and an asynchronous, active-high reset; ports are listed below.
REQ-008 clock  input  1  system clock, rising edge.
REQ-009 rst  input  1  asynchronous active-high reset.
REQ-010 adress  input  32  ALU result used as the word address.
REQ-011 writedata  input  DATA_W  store data.
REQ-012 MemWrite  input  1  store strobe.
REQ-013 in_req  input  1  the current instruction is IN; held high until the instruction retires.
REQ-014 btn_pulse  input  1  debounced, one-cycle button pulse.
REQ-015 switches  input  IN_W  board switches.
REQ-016 stall  output  1  freezes the PC and the register write.
REQ-017 in_data  output  DATA_W  captured input value.
REQ-018 in_valid  output  1  in_data is valid this cycle.
REQ-019 in_timeout  output  1  the last capture ended by timeout.
REQ-020 out_data  output  N_OUT*DATA_W  channel registers; channel i is at bits [i*DATA_W +: DATA_W].
REQ-021 out_strobe  output  N_OUT  one-cycle pulse per channel after that channel is written.
REQ-022 out_count  output  16  total accepted output writes, saturating.

Function
REQ-023 The input FSM SHALL have three states: IDLE, WAIT_BTN and DONE.
REQ-024 IDLE SHALL go to WAIT_BTN when in_req=1; btn_pulse in IDLE SHALL be ignored and SHALL NOT be latched.
REQ-025 In WAIT_BTN, btn_pulse=1 SHALL register switches into in_data, extended per SIGN_EXT, clear in_timeout and go to DONE.
REQ-026 In WAIT_BTN with TIMEOUT>0, the wait counter SHALL reach TIMEOUT-1 without a button.
- On that edge in_data SHALL become 0 and in_timeout SHALL become 1, with a transition to DONE.
- A button on the same edge SHALL win.
REQ-027 The wait counter SHALL clear on entry to WAIT_BTN and SHALL be sized to hold TIMEOUT.
REQ-028 DONE SHALL last exactly one cycle, with in_valid=1, then return to IDLE unconditionally.
REQ-029 stall SHALL be combinational: in_req AND (state != DONE) AND NOT rst.
- A back-to-back IN therefore re-enters WAIT_BTN from IDLE.
REQ-030 in_req dropping in WAIT_BTN SHALL return the FSM to IDLE with in_data unchanged.
REQ-031 A write SHALL be accepted when MemWrite=1 and 0 <= adress-BASE_ADDR < N_OUT.
- The channel index SHALL be adress-BASE_ADDR.
- The comparison SHALL be unsigned 32-bit, so addresses below BASE_ADDR wrap and are rejected.
REQ-032 An accepted write SHALL load the channel register at the clock edge.
- The same edge SHALL set that channel's out_strobe bit for one cycle.
- Other channels SHALL hold their values and keep their strobe bits 0.
REQ-033 Writes outside the channel range SHALL have no effect on any output.
REQ-034 out_count SHALL increment on every accepted write and saturate at 16'hFFFF.
REQ-035 Output writes and the input FSM SHALL operate independently; simultaneous events SHALL both take effect.
REQ-036 Back-to-back writes to the same channel SHALL keep out_strobe high for each cycle that has a write, with the last data winning.

Reset
REQ-037 rst=1 SHALL immediately force:
- FSM to IDLE;
- wait counter, in_data, in_timeout, in_valid, all channel registers, out_strobe and out_count to 0;
- stall to 0.
REQ-038 Reset asserted in WAIT_BTN or DONE SHALL abort the capture; after release, an in_req still high SHALL restart from IDLE.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
- IN with SIGN_EXT=1 and switches=16'h8001: in_req=1, btn after 5 cycles -> stall high for 6 cycles, then in_valid=1 for one cycle with in_data=32'hFFFF8001 and stall=0.
- The same stimulus with SIGN_EXT=0 -> in_data=32'h00008001.
- TIMEOUT=10 with no button -> in_data=0 and in_timeout=1 after 10 WAIT_BTN cycles; a button arriving on cycle 10 -> switch value captured and in_timeout=0.
- MemWrite to BASE_ADDR+2 with data 32'd1234 -> channel 2 = 1234 and out_strobe=4'b0100 for one cycle; writes to BASE_ADDR+4 and BASE_ADDR-1 -> no change.
- Two consecutive IN instructions (in_req held) -> two separate button waits and two in_valid pulses; a btn_pulse in IDLE -> ignored.
- rst pulsed mid-WAIT_BTN while in_req=1 -> stall=0 during reset, all outputs 0, FSM re-enters WAIT_BTN after release; 70000 writes -> out_count=16'hFFFF.
